// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the SRAM responder
// Contents: FSM state enum, default base address and depth, LFSR seed/taps,
// index-width helper.
package sram_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000;
    localparam int SRAM_DEPTH_DEF = 1024;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int SRAM_IDX_W = $clog2(SRAM_DEPTH_DEF);
    function automatic int idx_w(int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/sram_lfsr8.sv
// sram_lfsr8: 8-bit Fibonacci LFSR used to randomise response latency
// Ports: clk, rst (async active-low), step (advance one position), out (state).
module sram_lfsr8
    import sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] out
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out <= LFSR_SEED;
        else if (step) out <= {out[6:0], ^(out & LFSR_TAPS)};
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: word-organised on-chip SRAM serving the LSU request/response port
// Ports: clk, rst (async active-low); request req_valid/req_ready/req_wen/
// req_addr/req_wdata/req_wmask; response rsp_valid/rsp_ready/rsp_rdata/rsp_err.
// Optional macro SRAM_RANDOM_DELAY_EN adds 0..3 random wait cycles per request.
module sram_responder
    import sram_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR,
    parameter int          LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [7:0]        req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IW = idx_w(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

    state_t            state, nxt;
    logic [4:0]        cnt, ld;
    logic              wen_q, a_wen, accept, go, in_rng, unused_ok;
    logic [ADDR_W-1:0] addr_q, a_addr, off;
    logic [31:0]       wdata_q, a_wdata;
    logic [3:0]        wmask_q, a_wmask;
    logic [IW-1:0]     idx;
    logic [31:0]       mem [DEPTH];

`ifdef SRAM_RANDOM_DELAY_EN
    logic [7:0] lfsr;
    sram_lfsr8 u_lfsr (.clk(clk), .rst(rst), .step(accept), .out(lfsr));
    assign ld = 5'(LATENCY) + 5'(lfsr[1:0]);
    assign unused_ok = ^{req_wmask[7:4], lfsr[7:2]};
`else
    assign ld = 5'(LATENCY);
    assign unused_ok = ^req_wmask[7:4];
`endif

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_valid && req_ready;

    // A zero-wait access uses the live request; otherwise the latched copy.
    assign a_wen   = (state == IDLE) ? req_wen   : wen_q;
    assign a_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign a_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign a_wmask = (state == IDLE) ? req_wmask[3:0] : wmask_q;
    assign off     = a_addr - BASE;
    assign in_rng  = (a_addr >= BASE) && (off < SPAN);
    assign idx     = off[IW+1:2];

    always_comb begin
        nxt = state;
        go  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                go  = ld == 5'd0;
                nxt = (ld == 5'd0) ? RESP : WAIT;
            end
            WAIT: begin
                go  = cnt == 5'd1;
                nxt = (cnt == 5'd1) ? RESP : WAIT;
            end
            RESP:    nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            state <= nxt;
            cnt   <= accept ? ld : (cnt != 5'd0 ? cnt - 5'd1 : cnt);
            if (accept) begin
                wen_q   <= req_wen;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask[3:0];
            end
            if (go) begin
                rsp_err   <= !in_rng;
                rsp_rdata <= (in_rng && !a_wen) ? mem[idx] : '0;
            end
        end
    end

    // Storage is not reset; rst gating keeps a request seen during reset from writing.
    always_ff @(posedge clk) begin
        if (go && rst && in_rng && a_wen)
            for (int i = 0; i < 4; i++)
                if (a_wmask[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
    localparam int L = 1;
`ifdef SRAM_RANDOM_DELAY_EN
    localparam int XR = 3;
`else
    localparam int XR = 0;
`endif

    logic        clk = 1'b0, rst = 1'b0, sel = 1'b0;
    logic        req_valid = 1'b0, req_valid0 = 1'b0, req_wen = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        rsp_ready = 1'b0, rsp_ready0 = 1'b0;
    logic        req_ready, rsp_valid, rsp_err, req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata, rsp_rdata0;
    logic        rr, rv, re;
    logic [31:0] rd;
    int          checks = 0, errors = 0;
    logic [32:0] sb [$];
    logic [31:0] mdl [logic [32:0]];

    always #5 clk = ~clk;

    sram_responder #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    sram_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    assign rr = sel ? req_ready0 : req_ready;
    assign rv = sel ? rsp_valid0 : rsp_valid;
    assign re = sel ? rsp_err0   : rsp_err;
    assign rd = sel ? rsp_rdata0 : rsp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input bit s, input bit w, input logic [31:0] a,
                                          input logic [31:0] d, input logic [7:0] m);
        logic [32:0] k;
        logic [31:0] v;
        k = {s, a & 32'hFFFF_FFFC};
        if (a < 32'h8000_0000 || a >= 32'h8000_1000) return {1'b1, 32'h0};
        if (!w) return {1'b0, mdl.exists(k) ? mdl[k] : 32'hx};
        v = mdl.exists(k) ? mdl[k] : 32'hx;
        for (int i = 0; i < 4; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
        if (m[3:0] != 4'h0) mdl[k] = v;
        return {1'b0, 32'h0};
    endfunction

    task automatic txn(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] m, input int hold);
        logic [32:0] e;
        int n, lo;
        lo = s ? 1 : L + 1;
        @(negedge clk);
        sel = s; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m;
        if (s) req_valid0 = 1'b1; else req_valid = 1'b1;
        #1 chk("req_ready_idle", rr, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wmask = 8'($urandom);
        sb.push_back(model(s, w, a, d, m));
        n = 1;
        while (!rv && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("rsp_valid", rv, 1);
        chk("latency", (n >= lo && n <= lo + XR), 1);
        chk("req_ready_busy", rr, 0);
        e = sb.pop_front();
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", rv, 1);
            chk("hold_ready", rr, 0);
            chk("hold_data", rd, e[31:0]);
        end
        chk("rdata", rd, e[31:0]);
        chk("err", re, 32'(e[32]));
        if (s) rsp_ready0 = 1'b1; else rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0; rsp_ready0 = 1'b0;
        chk("rsp_done", rv, 0);
        chk("req_ready_after", rr, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        rst = 1'b1;
        txn(0, 1, 32'h8000_0010, 32'hDEADBEEF, 8'h0F, 0);
        txn(0, 0, 32'h8000_0010, 0, 0, 0);
        txn(0, 0, 32'h8000_0013, 0, 0, 0);
        txn(0, 1, 32'h8000_0020, 32'h11223344, 8'h0F, 0);
        txn(0, 1, 32'h8000_0020, 32'h0000AB00, 8'h02, 0);
        txn(0, 1, 32'h8000_0020, 32'hCD000000, 8'h08, 0);
        txn(0, 1, 32'h8000_0020, 32'hFFFFFFFF, 8'hF0, 0);
        txn(0, 0, 32'h8000_0020, 0, 0, 5);
        txn(0, 1, 32'h8000_0000, 32'hA5A50001, 8'h0F, 0);
        txn(0, 1, 32'h8000_1000, 32'h12121212, 8'h0F, 0);
        txn(0, 1, 32'h7FFF_FFFC, 32'h34343434, 8'h0F, 0);
        txn(0, 0, 32'h8000_1000, 0, 0, 0);
        txn(0, 0, 32'h8000_0000, 0, 0, 0);
        txn(0, 1, 32'h8000_0FFC, 32'h0BADF00D, 8'h0F, 0);
        txn(0, 0, 32'h8000_0FFC, 0, 0, 0);
        txn(0, 1, 32'h8000_0040, 32'h12345678, 8'h0F, 0);
        @(negedge clk);
        sel = 1'b0; req_valid = 1'b1; req_wen = 1'b1;
        req_addr = 32'h8000_0040; req_wdata = 32'h55AA55AA; req_wmask = 8'h0F;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        txn(0, 0, 32'h8000_0040, 0, 0, 0);
        txn(1, 1, 32'h8000_0100, 32'hCAFEF00D, 8'h0F, 0);
        txn(1, 0, 32'h8000_0100, 0, 0, 2);
        txn(1, 1, 32'h8000_2000, 32'h1, 8'h0F, 0);
        for (int i = 0; i < 8; i++) txn(0, 1, 32'h8000_0200 + 32'(4 * i), $urandom, 8'h0F, 0);
        for (int i = 0; i < 100; i++) begin
            a = 32'h8000_0200 + 32'(4 * $urandom_range(0, 7));
            txn(0, 0, a, 0, 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
